// File: rtl/idct_coef_loader_if.sv
// Coefficient stream, quantization-table write port and published block bus
// between the entropy decoder side and the IDCT coefficient loader.
interface idct_coef_loader_if #(
  parameter int unsigned WQ  = 11,
  parameter int unsigned WT  = 8,
  parameter int unsigned WIN = 12
) ();
  logic [WQ-1:0]     in_data;
  logic              in_valid;
  logic              in_eob;
  logic              in_ready;
  logic              q_we;
  logic [5:0]        q_addr;
  logic [WT-1:0]     q_data;
  logic [64*WIN-1:0] x;
  logic              out_valid;

  modport master (
    output in_data, in_valid, in_eob, q_we, q_addr, q_data,
    input  in_ready, x, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_eob, q_we, q_addr, q_data,
    output in_ready, x, out_valid
  );
endinterface

// File: rtl/idct_coef_loader.sv
// Dequantizes a zigzag-ordered coefficient stream, de-zigzags it into an 8x8
// raster buffer and publishes each completed block on a flat bus for the IDCT.
module idct_coef_loader #(
  parameter int unsigned WQ  = 11,
  parameter int unsigned WT  = 8,
  parameter int unsigned WIN = 12
) (
  input logic               clk,
  input logic               rst_n,
  idct_coef_loader_if.slave bus
);

  localparam int unsigned NCOEF = 64;
  localparam int unsigned WP    = WQ + WT + 1;
  localparam int unsigned WX    = NCOEF * WIN;

  localparam logic [5:0] ZZ [NCOEF] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic                ready_en_q;
  logic [5:0]          zz_q, zz_d;
  logic [WT-1:0]       q_tbl_q [NCOEF];

  logic                s1_valid_q, s1_valid_d;
  logic                s1_last_q, s1_last_d;
  logic [5:0]          s1_pos_q, s1_pos_d;
  logic [WIN-1:0]      s1_val_q, s1_val_d;

  logic [WIN-1:0]      buf_q [NCOEF];
  logic [NCOEF-1:0]    mask_q, mask_d;
  logic                pub_q, pub_d;
  logic [WX-1:0]       x_q, x_d;
  logic                out_valid_q, out_valid_d;

  logic                in_ready_c;
  logic                accept_c;
  logic                last_c;
  logic [5:0]          pos_c;
  logic signed [WQ-1:0] in_s_c;
  logic signed [WT:0]  q_s_c;
  logic signed [WP-1:0] prod_c;
  logic [WIN-1:0]      sat_c;
  logic [NCOEF-1:0]    bit_c;

  // Table writes win the cycle; the loader is held off until reset has released.
  assign in_ready_c = ready_en_q & ~bus.q_we;
  assign accept_c   = bus.in_valid & in_ready_c;

  // Stage 1: raster position, full-width dequantization and saturation.
  always_comb begin
    pos_c  = ZZ[zz_q];
    last_c = bus.in_eob | (zz_q == 6'd63);
    in_s_c = signed'(bus.in_data);
    q_s_c  = signed'({1'b0, q_tbl_q[pos_c]});
    prod_c = WP'(in_s_c) * WP'(q_s_c);
    if (prod_c[WP-1:WIN-1] == {(WP-WIN+1){prod_c[WP-1]}}) begin
      sat_c = prod_c[WIN-1:0];
    end else if (prod_c[WP-1]) begin
      sat_c = {1'b1, {(WIN-1){1'b0}}};
    end else begin
      sat_c = {1'b0, {(WIN-1){1'b1}}};
    end

    zz_d       = zz_q;
    s1_valid_d = accept_c;
    s1_last_d  = accept_c & last_c;
    s1_pos_d   = s1_pos_q;
    s1_val_d   = s1_val_q;
    if (accept_c) begin
      zz_d     = last_c ? 6'd0 : zz_q + 6'd1;
      s1_pos_d = pos_c;
      s1_val_d = sat_c;
    end
  end

  // Stage 2 and publish: a write landing on the publish edge starts the next mask.
  always_comb begin
    bit_c       = s1_valid_q ? (NCOEF'(1) << s1_pos_q) : '0;
    pub_d       = s1_valid_q & s1_last_q;
    mask_d      = pub_q ? bit_c : (mask_q | bit_c);
    out_valid_d = pub_q;
    x_d         = x_q;
    if (pub_q) begin
      for (int unsigned r = 0; r < NCOEF; r++) begin
        x_d[r*WIN +: WIN] = mask_q[r] ? buf_q[r] : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q  <= 1'b0;
      zz_q        <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_pos_q    <= '0;
      s1_val_q    <= '0;
      mask_q      <= '0;
      pub_q       <= 1'b0;
      x_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ready_en_q  <= 1'b1;
      zz_q        <= zz_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_pos_q    <= s1_pos_d;
      s1_val_q    <= s1_val_d;
      mask_q      <= mask_d;
      pub_q       <= pub_d;
      x_q         <= x_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Reset restores identity dequantization.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NCOEF; i++) begin
        q_tbl_q[i] <= WT'(1);
      end
    end else if (bus.q_we) begin
      q_tbl_q[bus.q_addr] <= bus.q_data;
    end
  end

  // Stale entries are masked off at publish, so the buffer needs no reset.
  always_ff @(posedge clk) begin
    if (s1_valid_q) begin
      buf_q[s1_pos_q] <= s1_val_q;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.x         = x_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: doc/idct_coef_loader.md
# idct_coef_loader

Upstream feeder for the `IDCT` core. It accepts a serial stream of quantized coefficients in JPEG zigzag order over a valid/ready handshake. Each coefficient is dequantized against a 64-entry table, saturated to 12 bits and de-zigzagged into raster position. Completed 8x8 blocks are published on the flat `x` bus consumed by `IDCT`, with a one-cycle `out_valid` strobe. The path sustains one coefficient per cycle with no bubbles between blocks.

## Interface
- `WQ`, 11: width of the signed quantized level input.
- `WT`, 8: width of the unsigned quantization table entry.
- `WIN`, 12: width of the signed dequantized coefficient; matches the `IDCT` input width.
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_data` in WQ: signed quantized level.
- `in_valid` in 1: `in_data` and `in_eob` are valid.
- `in_eob` in 1: this coefficient is the last non-zero one; all remaining positions are zero.
- `in_ready` out 1: coefficient is accepted on a clock edge where `in_valid` and `in_ready` are both high.
- `q_we` in 1: quantization table write enable.
- `q_addr` in 6: table address, indexed in raster order.
- `q_data` in WT: table entry to write.
- `x` out 64*WIN: published block; raster element r occupies `x[r*WIN +: WIN]`.
- `out_valid` out 1: one-cycle strobe marking a newly published `x`.

## Operation
- **Zigzag counter `zz` (6 bits).**
  - Increments on each accepted coefficient.
  - Returns to 0 after the coefficient with `zz==63` or `in_eob=1`; that coefficient ends the block.
  - `in_eob` on `zz==63` ends the block once, not twice.
- **Raster position** `pos = ZZ[zz]`, with ZZ = 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63.
- **Dequantization.**
  - Compute `in_data * Q[pos]` as a signed × unsigned product of full width (WQ+WT+1).
  - Clamp the result to [-2^(WIN-1), 2^(WIN-1)-1].
- **Fill buffer.**
  - 64 × WIN buffer plus a 64-bit written mask.
  - On publish, `x[r]` = buffer[r] if mask[r] is set, else 0. No explicit clearing of the buffer is needed.
- **Table writes.**
  - `q_we` has priority over input: `in_ready = !q_we` after reset.
  - A write affects only coefficients accepted on later edges.
- **Output hold.** `x` holds its value between publishes. `out_valid` is high for exactly one cycle per block.

## Timing
- **Reset (async assert)** clears all of the following:
  - `x=0`, `out_valid=0`, `in_ready=0`.
  - `zz=0`, mask=0, pipeline valid/last flags=0.
  - Q table set to all 1 (identity dequantization).
- `in_ready` goes high on the first clock after `rst_n` deasserts, unless `q_we` is high.
- **Pipeline.** For an accepting edge t:
  - Edge t: stage-1 registers capture `pos`, the saturated product and a last flag.
  - Edge t+1: buffer write and mask bit set.
  - If last, edge t+2: `x` is loaded and `out_valid=1` for the cycle following that edge.
- **Publish edge.** `x` samples the buffer and mask as they stood before this edge; any write on the same edge belongs to the next block.
  - On that edge the mask becomes only the bit being written, or 0 if none.
  - Blocks of any length, including 1, can be back-to-back; consecutive `out_valid` pulses are legal.
- **Bubbles.** Gaps in `in_valid` or `q_we` stalls do not disturb `zz` or the partial block.
- **Reset mid-block** discards the partial block and any pending publish. No `out_valid` pulse is emitted for it.
- **Protocol.** `in_data` and `in_eob` are don't-care when `in_valid=0`. `out_valid` must never be emitted for an empty block.

## Test plan
- **Identity table, IDCT test vector.** Stream 23,-1,0,0,0,-2 with `in_eob` on the 6th coefficient.
  - `out_valid` 2 cycles after the last accept.
  - `x[0]=23`, `x[1]=-1`, `x[2]=-2`, all other elements 0.
  - Feeding this `x` to `IDCT` yields the known block: 2 in column 0, 3 elsewhere.
- **Full block, zigzag mapping.** Stream 64 coefficients with values 0..63 and no EOB.
  - `x[ZZ[n]]=n` for every n.
  - Exactly one `out_valid`.
- **Dequantization and saturation.**
  - Table: `Q[0]=200`, `Q[1]=3`.
  - Stream 100, then -5 with EOB → `x[0]=2047` (clamped from 20000), `x[1]=-15`.
  - Stream -1024 alone with EOB → `x[0]=-2048`.
- **Back-to-back 1-coefficient blocks.** Stream 7(EOB) then 9(EOB) on consecutive cycles.
  - `out_valid` on two consecutive cycles.
  - First `x[0]=7`, second `x[0]=9`.
  - No stale data: all other elements 0 in both blocks.
- **Stall and table write.** Hold `q_we=1` for 3 cycles mid-block with `in_valid=1`.
  - `in_ready=0` for those cycles and no coefficient is lost.
  - A write to `Q[pos]` before that position's coefficient is accepted takes effect on it.
- **Reset mid-block.** Accept 10 coefficients, pulse `rst_n` low, then stream 5(EOB).
  - No `out_valid` before the new block.
  - Result `x[0]=5`, all other elements 0; table back to identity.
